// File: rtl/hazard_controller.sv
// hazard_controller: load-use bubble insertion, taken-branch flushing and
// pipeline freeze for the request/acknowledge handshake of a MEM-stage load/store.
// Optional build macro: HAZ_PERF_CNT_EN enables the saturating 16-bit
// performance counters; without it the counter ports read 0.
//
// Memory FSM
//   state  | meaning
//   IDLE   | no access pending; a load/store in MEM freezes and starts a request
//   WAIT   | Mem_Req high, pipeline frozen, waiting for Mem_Ack or timeout
//   DONE   | access finished, pipeline released so the MEM instruction advances
module hazard_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs_D,
    input  logic [4:0]  Rt_D,
    input  logic        Use_Rt_D,
    input  logic        Mem_Read_E,
    input  logic [4:0]  Rt_E,
    input  logic        PC_Src_E,
    input  logic        Mem_Read_M,
    input  logic        Mem_Write_M,
    input  logic        Mem_Ack,
    output logic        Stall_F,
    output logic        Stall_D,
    output logic        Stall_E,
    output logic        Stall_M,
    output logic        Flush_D,
    output logic        Flush_E,
    output logic        Mem_Req,
    output logic        Mem_Err,
    output logic [15:0] Load_Use_Cnt,
    output logic [15:0] Mem_Stall_Cnt,
    output logic [15:0] Flush_Cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } mem_state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_t state, state_nxt;
    logic [7:0] tmo_cnt;
    logic       mem_freeze;
    logic       timeout_hit;
    logic       load_use;
    logic       mem_req_q;
    logic       mem_err_q;

    // Raw load-use detection; $zero never carries a real dependency.
    assign load_use = Mem_Read_E && (Rt_E != 5'd0) &&
                      ((Rt_E == Rs_D) || (Use_Rt_D && (Rt_E == Rt_D)));

    // Next-state and freeze decode; an ack coinciding with timeout counts as success.
    always_comb begin
        state_nxt   = state;
        mem_freeze  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (Mem_Read_M || Mem_Write_M) begin
                    state_nxt  = S_WAIT;
                    mem_freeze = 1'b1;
                end
            end
            S_WAIT: begin
                mem_freeze = 1'b1;
                if (Mem_Ack) begin
                    state_nxt = S_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt   = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stall/flush priority: freeze, then taken branch, then load-use; all low in reset.
    always_comb begin
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Stall_E = 1'b0;
        Stall_M = 1'b0;
        Flush_D = 1'b0;
        Flush_E = 1'b0;
        if (rst_n) begin
            if (mem_freeze) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Stall_E = 1'b1;
                Stall_M = 1'b1;
            end else if (PC_Src_E) begin
                Flush_D = 1'b1;
                Flush_E = 1'b1;
            end else if (load_use) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Flush_E = 1'b1;
            end
        end
    end

    // State register, WAIT timeout counter, registered request and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tmo_cnt   <= 8'd0;
            mem_req_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmo_cnt   <= (state == S_WAIT) ? tmo_cnt + 8'd1 : 8'd0;
            mem_req_q <= (state_nxt == S_WAIT);
            if (timeout_hit) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    assign Mem_Req = mem_req_q;
    assign Mem_Err = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
    logic        ev_load_use;
    logic        ev_flush;
    logic [15:0] lu_cnt_q;
    logic [15:0] ms_cnt_q;
    logic [15:0] fl_cnt_q;

    assign ev_load_use = !mem_freeze && !PC_Src_E && load_use;
    assign ev_flush    = !mem_freeze && PC_Src_E;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lu_cnt_q <= 16'd0;
            ms_cnt_q <= 16'd0;
            fl_cnt_q <= 16'd0;
        end else begin
            if (ev_load_use && (lu_cnt_q != 16'hFFFF)) lu_cnt_q <= lu_cnt_q + 16'd1;
            if (mem_freeze  && (ms_cnt_q != 16'hFFFF)) ms_cnt_q <= ms_cnt_q + 16'd1;
            if (ev_flush    && (fl_cnt_q != 16'hFFFF)) fl_cnt_q <= fl_cnt_q + 16'd1;
        end
    end

    assign Load_Use_Cnt  = lu_cnt_q;
    assign Mem_Stall_Cnt = ms_cnt_q;
    assign Flush_Cnt     = fl_cnt_q;
`else
    assign Load_Use_Cnt  = 16'd0;
    assign Mem_Stall_Cnt = 16'd0;
    assign Flush_Cnt     = 16'd0;
`endif

endmodule
